// File: rtl/dhbs.sv
// dhbs: four-bit up/down wrap-around counter stepped by a programmable clock prescaler
module dhbs #(
  parameter int CLK_DIV = 1,
  parameter int MODULUS = 16
) (
  input  logic       dhbs_clk,
  input  logic       dhbs_rst,
  input  logic       dhbs_sel,
  output logic [3:0] dhbs_q
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PC_TOP = PW'(CLK_DIV - 1);
  localparam logic [3:0] CNT_TOP = 4'(MODULUS - 1);
  if (CLK_DIV < 1 || CLK_DIV > 2**24 || MODULUS < 2 || MODULUS > 16) begin : g_bad_param
    $fatal(1, "dhbs: illegal CLK_DIV or MODULUS");
  end
  logic [PW-1:0] pc_q, pc_d;
  logic [3:0] cnt_q, cnt_d;
  logic tick;
  always_comb begin
    tick = (pc_q == PC_TOP);
    pc_d = tick ? '0 : pc_q + PW'(1);
    cnt_d = !tick ? cnt_q :
            dhbs_sel ? ((cnt_q == CNT_TOP) ? 4'd0 : cnt_q + 4'd1) :
                       ((cnt_q == 4'd0) ? CNT_TOP : cnt_q - 4'd1);
  end
  always_ff @(posedge dhbs_clk or negedge dhbs_rst) begin
    if (!dhbs_rst) begin
      pc_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
    end
  end
  assign dhbs_q = cnt_q;
endmodule

// File: tb/tb_dhbs.sv
// tb_dhbs: directed vector bench for default, divided and modulus-10 counters
module tb_dhbs;
  logic clk = 1'b0;
  logic rst_def = 1'b0, sel_def = 1'b1;
  logic rst_div = 1'b0, sel_div = 1'b1;
  logic rst_mod = 1'b0, sel_mod = 1'b1;
  logic [3:0] q_def, q_div, q_mod;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  dhbs u_def (.dhbs_clk(clk), .dhbs_rst(rst_def), .dhbs_sel(sel_def), .dhbs_q(q_def));
  dhbs #(.CLK_DIV(4)) u_div (.dhbs_clk(clk), .dhbs_rst(rst_div), .dhbs_sel(sel_div), .dhbs_q(q_div));
  dhbs #(.MODULUS(10)) u_mod (.dhbs_clk(clk), .dhbs_rst(rst_mod), .dhbs_sel(sel_mod), .dhbs_q(q_mod));
  typedef struct {
    logic rst;
    logic sel;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    vecs.push_back('{1'b0, 1'b1, 4'h0});
    for (int i = 1; i <= 20; i++) vecs.push_back('{1'b1, 1'b1, 4'(i % 16)});
    for (int i = 1; i <= 15; i++) vecs.push_back('{1'b1, 1'b0, 4'(4 - i)});
    vecs.push_back('{1'b1, 1'b1, 4'h6});
    vecs.push_back('{1'b1, 1'b0, 4'h5});
    vecs.push_back('{1'b1, 1'b1, 4'h6});
    vecs.push_back('{1'b1, 1'b0, 4'h5});
    #1;
    chk("div_reset", q_div, 4'h0);
    chk("mod_reset", q_mod, 4'h0);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_def = vecs[i].rst;
      sel_def = vecs[i].sel;
      @(posedge clk);
      #1 chk($sformatf("tbl[%0d]", i), q_def, vecs[i].exp);
    end
    @(negedge clk);
    sel_def = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_9", q_def, 4'h9);
    #2 rst_def = 1'b0;
    #1 chk("async_reset", q_def, 4'h0);
    @(negedge clk);
    rst_def = 1'b1;
    sel_def = 1'b1;
    @(posedge clk);
    #1 chk("release_up", q_def, 4'h1);
    @(negedge clk);
    rst_def = 1'b0;
    @(negedge clk);
    rst_def = 1'b1;
    sel_def = 1'b0;
    @(posedge clk);
    #1 chk("release_down", q_def, 4'hF);
    @(negedge clk);
    rst_div = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1 chk($sformatf("div_edge%0d", e), q_div, 4'(e / 4));
    end
    @(negedge clk);
    rst_mod = 1'b1;
    sel_mod = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1 chk($sformatf("mod_up%0d", e), q_mod, 4'(e % 10));
    end
    @(negedge clk);
    sel_mod = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1 chk($sformatf("mod_dn%0d", e), q_mod, 4'((12 - e) % 10));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
